// File: rtl/mc_mem_responder.sv
// Word-organised memory responder: one read/write request at a time over valid/ready.
// Latency: rsp_valid goes high LATENCY cycles after the accept edge and stays high for one cycle.
// Backpressure: req_ready is low from accept until the response has been given, so accepts are never back-to-back.
module mc_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [3:0]     r_cnt;
  logic           r_ready;
  logic           r_rsp_valid;
  logic [31:0]    r_rdata;
  logic           r_err;
  logic           r_write;
  logic [31:0]    r_addr;
  logic [31:0]    r_wdata;
  logic [3:0]     r_wstrb;
  logic [31:0]    r_mem [DEPTH_WORDS];

  logic           w_accept;
  logic [31:0]    w_addr;
  logic           w_write;
  logic           w_err;
  logic [AW-1:0]  w_idx;
  logic           w_enter_resp;

  // While idle the request is still on the inputs (matters for LATENCY==1); afterwards use the latched copy.
  assign w_accept     = req_valid & r_ready;
  assign w_addr       = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_write      = (r_state == S_IDLE) ? req_write : r_write;
  assign w_err        = (w_addr[1:0] != 2'b00) | (w_addr[31:2] >= DEPTH_W);
  assign w_idx        = w_addr[AW+1:2];
  assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // Next-state logic: IDLE -> (WAIT ->) RESP -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, wait counter and registered handshake outputs; ready/valid follow the next state so they are glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_ready     <= (w_next == S_IDLE);
      r_rsp_valid <= (w_next == S_RESP);
      if (r_state == S_IDLE && w_accept)
        r_cnt <= CNT_INIT;
      else if (r_state == S_WAIT && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
    end
  end

  // Request capture at accept, so later input changes cannot disturb the request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
    end else if (r_state == S_IDLE && w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_wstrb <= req_wstrb;
    end
  end

  // Response data/error load on entry to RESP and then hold until the next response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_rdata <= (!w_err && !w_write) ? r_mem[w_idx] : 32'd0;
      r_err   <= w_err;
    end
  end

  // Array write at the edge ending RESP; reset forces IDLE first, so an aborted write never commits.
  always_ff @(posedge clk) begin
    if (r_state == S_RESP && r_write && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (r_wstrb[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mc_mem_responder.sv
// Directed bench for mc_mem_responder: one LATENCY=2 instance and one LATENCY=1 instance.
// Latency: responses observed on the falling edge, counted from the accept edge.
// Backpressure: requests held until req_ready, then dropped and scrambled.
module tb_mc_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0;
  logic        b_valid = 1'b0;
  logic        write = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic        a_ready, a_rsp_valid, a_err;
  logic [31:0] a_rdata;
  logic        b_ready, b_rsp_valid, b_err;
  logic [31:0] b_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready),
    .req_write(write), .req_addr(addr), .req_wdata(wdata), .req_wstrb(wstrb),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_err)
  );

  mc_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready),
    .req_write(write), .req_addr(addr), .req_wdata(wdata), .req_wstrb(wstrb),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_err)
  );

  // Issue one request to instance A (sel=0) or B (sel=1) and report what was observed.
  // lat: falling edges after accept until rsp_valid; busy: falling edges with req_ready low; npulse: rsp_valid cycles.
  task automatic do_req(input bit sel, input logic w, input logic [31:0] ad, input logic [31:0] wd,
                        input logic [3:0] st, output int lat, output int busy, output int npulse,
                        output logic [31:0] rd, output logic er);
    int guard;
    lat = -1; busy = 0; npulse = 0; rd = 32'hxxxx_xxxx; er = 1'bx;
    @(negedge clk);
    write = w; addr = ad; wdata = wd; wstrb = st;
    if (sel) b_valid = 1'b1; else a_valid = 1'b1;
    guard = 0;
    while (!(sel ? b_ready : a_ready) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      a_valid = 1'b0; b_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (n == 1) begin
        a_valid = 1'b0; b_valid = 1'b0;
        write = ~w; addr = 32'hFFFF_FFF0; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
      end
      if (sel ? b_rsp_valid : a_rsp_valid) begin
        npulse++;
        if (lat < 0) begin
          lat = n;
          rd  = sel ? b_rdata : a_rdata;
          er  = sel ? b_err : a_err;
        end
      end
      if (sel ? b_ready : a_ready) break;
      busy++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %b want 0", a_ready); end
    checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_a_rsp_valid: got %b want 0", a_rsp_valid); end
    checks++; if (a_rdata !== 32'd0) begin errors++; $display("FAIL reset_a_rdata: got %h want 0", a_rdata); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_a_err: got %b want 0", a_err); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready: got %b want 0", b_ready); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", a_ready); end
  endtask

  task automatic test_write_read();
    int lat, busy, np; logic [31:0] rd; logic er;
    do_req(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, busy, np, rd, er);
    checks++; if (lat != 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", er); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL wr_rdata: got %h want 0", rd); end
    checks++; if (busy != 2) begin errors++; $display("FAIL wr_busy: got %0d want 2", busy); end
    checks++; if (np != 1) begin errors++; $display("FAIL wr_pulses: got %0d want 1", np); end
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, lat, busy, np, rd, er);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    checks++; if (lat != 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", er); end
    @(negedge clk);
    checks++; if (a_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_hold: got %h want deadbeef", a_rdata); end
  endtask

  task automatic test_strobes();
    int lat, busy, np; logic [31:0] rd; logic er;
    do_req(1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, lat, busy, np, rd, er);
    do_req(1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'h5, lat, busy, np, rd, er);
    do_req(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, lat, busy, np, rd, er);
    checks++; if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL strobe_merge: got %h want 11bb33dd", rd); end
    do_req(1'b0, 1'b1, 32'h20, 32'h0, 4'h0, lat, busy, np, rd, er);
    checks++; if (er !== 1'b0 || lat != 2) begin errors++; $display("FAIL strobe_zero_rsp: got err=%b lat=%0d want err=0 lat=2", er, lat); end
    do_req(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, lat, busy, np, rd, er);
    checks++; if (rd !== 32'h11BB_33DD) begin errors++; $display("FAIL strobe_zero_nochange: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_errors();
    int lat, busy, np; logic [31:0] rd; logic er;
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, lat, busy, np, rd, er);
    do_req(1'b0, 1'b0, 32'h13, 32'h0, 4'h0, lat, busy, np, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b want 1", er); end
    checks++; if (rd !== 32'd0) begin errors++; $display("FAIL misalign_rdata: got %h want 0", rd); end
    checks++; if (lat != 2) begin errors++; $display("FAIL misalign_latency: got %0d want 2", lat); end
    do_req(1'b0, 1'b0, 32'h1000, 32'h0, 4'h0, lat, busy, np, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL range_err: got %b want 1", er); end
    do_req(1'b0, 1'b0, 32'hFFC, 32'h0, 4'h0, lat, busy, np, rd, er);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL last_word_err: got %b want 0", er); end
    do_req(1'b0, 1'b1, 32'h12, 32'h0, 4'hF, lat, busy, np, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_wr_err: got %b want 1", er); end
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, lat, busy, np, rd, er);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL misalign_wr_nochange: got %h want deadbeef", rd); end
    do_req(1'b0, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, lat, busy, np, rd, er);
    do_req(1'b0, 1'b1, 32'h1000, 32'h0, 4'hF, lat, busy, np, rd, er);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL range_wr_err: got %b want 1", er); end
    do_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, lat, busy, np, rd, er);
    checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL range_wr_nochange: got %h want cafef00d", rd); end
  endtask

  task automatic test_back_to_back();
    int rc, sc, badgap, last;
    rc = 0; sc = 0; badgap = 0; last = -1;
    @(negedge clk);
    write = 1'b0; addr = 32'h10; wstrb = 4'h0; a_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      if (a_ready && i < 29) begin
        rc++;
        if (last >= 0 && (i - last) != 3) badgap++;
        last = i;
      end
      if (a_rsp_valid) sc++;
      if (i == 29) a_valid = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_rsp_valid) sc++;
    end
    checks++; if (rc != 10) begin errors++; $display("FAIL b2b_accepts: got %0d want 10", rc); end
    checks++; if (sc != rc) begin errors++; $display("FAIL b2b_responses: got %0d want %0d", sc, rc); end
    checks++; if (badgap != 0) begin errors++; $display("FAIL b2b_spacing: got %0d bad gaps want 0", badgap); end
  endtask

  task automatic test_reset_abort();
    int lat, busy, np; logic [31:0] rd; logic er;
    do_req(1'b0, 1'b1, 32'h8, 32'h1234_5678, 4'hF, lat, busy, np, rd, er);
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, lat, busy, np, rd, er);
    @(negedge clk);
    write = 1'b1; addr = 32'h8; wdata = 32'h0000_0055; wstrb = 4'hF; a_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL abort_in_wait: got ready=%b want 0", a_ready); end
    rst = 1'b0;
    #1;
    checks++; if (a_ready !== 1'b0 || a_rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_handshake: got ready=%b rsp_valid=%b want 0 0", a_ready, a_rsp_valid); end
    checks++; if (a_rdata !== 32'd0 || a_err !== 1'b0) begin errors++; $display("FAIL abort_rsp_regs: got rdata=%h err=%b want 0 0", a_rdata, a_err); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_req(1'b0, 1'b0, 32'h8, 32'h0, 4'h0, lat, busy, np, rd, er);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL abort_no_commit: got %h want 12345678", rd); end
  endtask

  task automatic test_latency1();
    int lat, busy, np; logic [31:0] rd; logic er;
    do_req(1'b1, 1'b1, 32'h40, 32'h0BAD_F00D, 4'hF, lat, busy, np, rd, er);
    checks++; if (lat != 1) begin errors++; $display("FAIL l1_wr_latency: got %0d want 1", lat); end
    checks++; if (busy != 1) begin errors++; $display("FAIL l1_wr_busy: got %0d want 1", busy); end
    checks++; if (np != 1) begin errors++; $display("FAIL l1_wr_pulses: got %0d want 1", np); end
    do_req(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, busy, np, rd, er);
    checks++; if (rd !== 32'h0BAD_F00D || er !== 1'b0) begin errors++; $display("FAIL l1_rd: got %h err=%b want 0badf00d err=0", rd, er); end
    checks++; if (lat != 1 || busy != 1) begin errors++; $display("FAIL l1_rd_timing: got lat=%0d busy=%0d want 1 1", lat, busy); end
    do_req(1'b1, 1'b0, 32'h41, 32'h0, 4'h0, lat, busy, np, rd, er);
    checks++; if (er !== 1'b1 || rd !== 32'd0 || lat != 1) begin errors++; $display("FAIL l1_err: got err=%b rdata=%h lat=%0d want 1 0 1", er, rd, lat); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobes();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_latency1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
